// File: rtl/drive_pkg.sv
// Shared encodings for the line-following drive sequencer.
package drive_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_STRAIGHT  = 3'd1,
        ST_TURN_L    = 3'd2,
        ST_TURN_R    = 3'd3,
        ST_SEARCH    = 3'd4,
        ST_OBST_WAIT = 3'd5,
        ST_HALT      = 3'd6
    } state_e;

    // Raw/qualified tracker codes
    localparam logic [1:0] TRK_LEFT   = 2'b00;
    localparam logic [1:0] TRK_RIGHT  = 2'b01;
    localparam logic [1:0] TRK_CENTRE = 2'b10;
    localparam logic [1:0] TRK_LOST   = 2'b11;

    // PWM speed codes
    localparam logic [2:0] MODE_STOP   = 3'd0;
    localparam logic [2:0] MODE_TURN   = 3'd1;
    localparam logic [2:0] MODE_CRUISE = 3'd2;
    localparam logic [2:0] MODE_SEARCH = 3'd3;

    // Per-wheel direction pairs
    localparam logic [1:0] WHEEL_FWD = 2'b10;
    localparam logic [1:0] WHEEL_OFF = 2'b00;

    typedef enum logic {
        DIR_L = 1'b0,
        DIR_R = 1'b1
    } dir_e;

    typedef struct packed {
        logic [1:0] left;
        logic [1:0] right;
        logic [2:0] mode;
    } drive_out_t;

    // Steering state selected by a qualified track code
    function automatic state_e track_next(input logic [1:0] trk);
        state_e st;
        case (trk)
            TRK_CENTRE: st = ST_STRAIGHT;
            TRK_LEFT:   st = ST_TURN_L;
            TRK_RIGHT:  st = ST_TURN_R;
            default:    st = ST_SEARCH;
        endcase
        return st;
    endfunction

    // Moore output pattern for a state; SEARCH sweeps toward the last turn
    function automatic drive_out_t decode_out(input state_e st, input dir_e dir);
        drive_out_t o;
        o = '{left: WHEEL_OFF, right: WHEEL_OFF, mode: MODE_STOP};
        case (st)
            ST_STRAIGHT: o = '{left: WHEEL_FWD, right: WHEEL_FWD, mode: MODE_CRUISE};
            ST_TURN_L:   o = '{left: WHEEL_OFF, right: WHEEL_FWD, mode: MODE_TURN};
            ST_TURN_R:   o = '{left: WHEEL_FWD, right: WHEEL_OFF, mode: MODE_TURN};
            ST_SEARCH: begin
                if (dir == DIR_L) o = '{left: WHEEL_OFF, right: WHEEL_FWD, mode: MODE_SEARCH};
                else              o = '{left: WHEEL_FWD, right: WHEEL_OFF, mode: MODE_SEARCH};
            end
            default: o = '{left: WHEEL_OFF, right: WHEEL_OFF, mode: MODE_STOP};
        endcase
        return o;
    endfunction

endpackage

// File: rtl/track_filter.sv
// Debounces the raw tracker code: a new code is accepted only after
// FILT_CYC consecutive identical samples.
module track_filter
    import drive_pkg::*;
#(
    parameter int unsigned FILT_CYC = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] raw_i,
    output logic [1:0] q_track_o
);

    localparam int unsigned CW = 8;
    localparam logic [CW-1:0] CNT_FULL = CW'(FILT_CYC);

    logic [1:0]    last_q;
    logic [1:0]    q_track_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Run length of the current raw code, counting this sample; saturates
    always_comb begin
        cnt_d = cnt_q;
        if (raw_i != last_q) begin
            cnt_d = CW'(1);
        end else if (cnt_q < CNT_FULL) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Sample history and qualified code
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q    <= TRK_CENTRE;
            cnt_q     <= '0;
            q_track_q <= TRK_CENTRE;
        end else begin
            last_q <= raw_i;
            cnt_q  <= cnt_d;
            if (cnt_d == CNT_FULL) begin
                q_track_q <= raw_i;
            end
        end
    end

    assign q_track_o = q_track_q;

endmodule

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: steering FSM with lost-line timeout
// and obstacle hold-off, Moore-decoded wheel outputs.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int unsigned FILT_CYC = 4,
    parameter int unsigned LOST_CYC = 50_000_000,
    parameter int unsigned HOLD_CYC = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] track_state,
    input  logic       obstacle,
    output logic [1:0] left,
    output logic [1:0] right,
    output logic [2:0] mode,
    output logic [2:0] seq_state
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] LOST_LAST = CNT_W'(LOST_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]       q_track;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] search_q, search_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    dir_e             last_dir_q, last_dir_d;
    drive_out_t       out_c;

    track_filter #(
        .FILT_CYC (FILT_CYC)
    ) u_track_filter (
        .clk       (clk),
        .rst       (rst),
        .raw_i     (track_state),
        .q_track_o (q_track)
    );

    // State, counters and last turn direction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            search_q   <= '0;
            hold_q     <= '0;
            last_dir_q <= DIR_L;
        end else begin
            state_q    <= state_d;
            search_q   <= search_d;
            hold_q     <= hold_d;
            last_dir_q <= last_dir_d;
        end
    end

    // Next state; priority is enable, obstacle, lost-line timeout, track
    always_comb begin
        state_d    = state_q;
        search_d   = search_q;
        hold_d     = hold_q;
        last_dir_d = last_dir_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            search_d = '0;
            hold_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: state_d = ST_STRAIGHT;
                ST_STRAIGHT, ST_TURN_L, ST_TURN_R: begin
                    search_d = '0;
                    if (obstacle) begin
                        state_d = ST_OBST_WAIT;
                        hold_d  = '0;
                    end else begin
                        state_d = track_next(q_track);
                    end
                end
                ST_SEARCH: begin
                    if (obstacle) begin
                        state_d  = ST_OBST_WAIT;
                        search_d = '0;
                        hold_d   = '0;
                    end else if (search_q == LOST_LAST) begin
                        state_d = ST_HALT;
                    end else if (q_track != TRK_LOST) begin
                        state_d  = track_next(q_track);
                        search_d = '0;
                    end else if (search_q != CNT_MAX) begin
                        search_d = search_q + CNT_W'(1);
                    end
                end
                ST_OBST_WAIT: begin
                    if (obstacle) begin
                        hold_d = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = ST_STRAIGHT;
                        hold_d  = '0;
                    end else if (hold_q != CNT_MAX) begin
                        hold_d = hold_q + CNT_W'(1);
                    end
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end

        if (state_d == ST_TURN_L) last_dir_d = DIR_L;
        if (state_d == ST_TURN_R) last_dir_d = DIR_R;
    end

    // Moore output decode of the state register
    always_comb begin
        out_c = decode_out(state_q, last_dir_q);
    end

    assign left      = out_c.left;
    assign right     = out_c.right;
    assign mode      = out_c.mode;
    assign seq_state = state_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed scoreboard bench for drive_sequencer (FILT=4, LOST=20, HOLD=8).
module tb_drive_sequencer;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [1:0] track_state;
    logic       obstacle;
    logic [1:0] left;
    logic [1:0] right;
    logic [2:0] mode;
    logic [2:0] seq_state;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        int         due;
        string      tag;
        logic [9:0] exp;
    } sb_t;

    sb_t sb[$];
    sb_t mon_e;

    // Expected {seq_state, left, right, mode}
    localparam logic [9:0] E_IDLE     = {3'd0, 2'b00, 2'b00, 3'd0};
    localparam logic [9:0] E_STRAIGHT = {3'd1, 2'b10, 2'b10, 3'd2};
    localparam logic [9:0] E_TURN_L   = {3'd2, 2'b00, 2'b10, 3'd1};
    localparam logic [9:0] E_TURN_R   = {3'd3, 2'b10, 2'b00, 3'd1};
    localparam logic [9:0] E_SEARCH_L = {3'd4, 2'b00, 2'b10, 3'd3};
    localparam logic [9:0] E_SEARCH_R = {3'd4, 2'b10, 2'b00, 3'd3};
    localparam logic [9:0] E_OBST     = {3'd5, 2'b00, 2'b00, 3'd0};
    localparam logic [9:0] E_HALT     = {3'd6, 2'b00, 2'b00, 3'd0};

    drive_sequencer #(
        .FILT_CYC (4),
        .LOST_CYC (20),
        .HOLD_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .track_state (track_state),
        .obstacle    (obstacle),
        .left        (left),
        .right       (right),
        .mode        (mode),
        .seq_state   (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string tag, input logic [9:0] exp);
        logic [9:0] obs;
        obs = {seq_state, left, right, mode};
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed state=%0d lr=%b mode=%0d, expected state=%0d lr=%b mode=%0d",
                   tag, obs[9:7], obs[6:3], obs[2:0], exp[9:7], exp[6:3], exp[2:0]);
        end
    endtask

    // Queue an expectation for the state after dly more rising edges
    task automatic expect_at(input int dly, input string tag, input logic [9:0] exp);
        sb_t e;
        e.due = cyc + dly;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard checker, sampling on the falling edge
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.due == cyc) begin
                compare(mon_e.tag, mon_e.exp);
            end else begin
                vectors++;
                miscompares++;
                $display("FAIL %s: expectation for cycle %0d sampled at cycle %0d", mon_e.tag, mon_e.due, cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sb_t left_e;
        rst         = 1'b1;
        enable      = 1'b0;
        track_state = 2'b10;
        obstacle    = 1'b0;
        tick(1);
        compare("reset_state", E_IDLE);
        tick(1);
        rst = 1'b0;

        // Start up centred
        enable = 1'b1;
        expect_at(1, "idle_to_straight", E_STRAIGHT);
        expect_at(4, "straight_hold", E_STRAIGHT);
        tick(4);

        // Left turn with filter latency, then a short glitch
        track_state = 2'b00;
        expect_at(4, "turn_l_not_early", E_STRAIGHT);
        expect_at(5, "turn_l_latency", E_TURN_L);
        tick(5);
        track_state = 2'b01;
        expect_at(3, "glitch_during", E_TURN_L);
        tick(3);
        track_state = 2'b00;
        expect_at(1, "glitch_no_turn_r", E_TURN_L);
        expect_at(5, "glitch_after", E_TURN_L);
        tick(5);

        // Right turn, lose the line, time out into HALT
        track_state = 2'b01;
        expect_at(5, "turn_r", E_TURN_R);
        tick(5);
        track_state = 2'b11;
        expect_at(4, "search_not_early", E_TURN_R);
        expect_at(5, "search_dir_r", E_SEARCH_R);
        expect_at(24, "search_pre_timeout", E_SEARCH_R);
        expect_at(25, "halt_timeout", E_HALT);
        tick(25);
        track_state = 2'b10;
        obstacle    = 1'b1;
        expect_at(10, "halt_sticky", E_HALT);
        tick(10);
        enable = 1'b0;
        expect_at(1, "halt_to_idle", E_IDLE);
        tick(1);
        enable = 1'b1;
        expect_at(1, "idle_ignores_obst", E_STRAIGHT);
        tick(1);

        // Obstacle still high: stop, partial clear, reassert, full clear
        expect_at(1, "obst_stop_1cyc", E_OBST);
        tick(1);
        obstacle = 1'b0;
        expect_at(5, "obst_clear5", E_OBST);
        tick(5);
        obstacle = 1'b1;
        tick(1);
        obstacle = 1'b0;
        expect_at(7, "obst_clear7", E_OBST);
        expect_at(8, "obst_resume", E_STRAIGHT);
        tick(8);

        // enable beats obstacle on the same edge
        obstacle = 1'b1;
        enable   = 1'b0;
        expect_at(1, "enable_beats_obst", E_IDLE);
        tick(1);
        obstacle = 1'b0;
        enable   = 1'b1;
        expect_at(1, "restart", E_STRAIGHT);
        tick(1);

        // obstacle beats lost-line timeout on the same edge
        track_state = 2'b11;
        expect_at(5, "search2_dir_r", E_SEARCH_R);
        expect_at(24, "search2_pre_timeout", E_SEARCH_R);
        tick(24);
        obstacle = 1'b1;
        expect_at(1, "obst_beats_timeout", E_OBST);
        tick(1);
        obstacle = 1'b0;
        expect_at(7, "obst2_clear7", E_OBST);
        expect_at(8, "obst2_resume", E_STRAIGHT);
        expect_at(9, "back_to_search", E_SEARCH_R);
        tick(9);

        // Asynchronous reset mid-SEARCH, between edges
        tick(3);
        #2 rst = 1'b1;
        #1 compare("async_reset_out", E_IDLE);
        track_state = 2'b10;
        tick(1);
        compare("reset_held", E_IDLE);
        rst = 1'b0;
        expect_at(1, "post_reset_straight", E_STRAIGHT);
        tick(1);
        track_state = 2'b11;
        expect_at(5, "post_reset_dir_l", E_SEARCH_L);
        expect_at(24, "post_reset_pre_timeout", E_SEARCH_L);
        expect_at(25, "post_reset_halt", E_HALT);
        tick(26);

        tick(2);
        while (sb.size() > 0) begin
            left_e = sb.pop_front();
            vectors++;
            miscompares++;
            $display("FAIL %s: expectation for cycle %0d never sampled", left_e.tag, left_e.due);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 The block SHALL have parameter FILT_CYC, default 4, meaning consecutive identical track samples needed to qualify a new track code (range 1..255).
REQ-002 The block SHALL have parameter LOST_CYC, default 50_000_000, meaning cycles in SEARCH before HALT (range 1..2^32-1).
REQ-003 The block SHALL have parameter HOLD_CYC, default 25_000_000, meaning consecutive obstacle-clear cycles before resuming (range 1..2^32-1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port enable, input, 1 bit: run request; level-sensitive.
REQ-007 The block SHALL have port track_state, input, 2 bits: tracker code, where 00=line left, 01=line right, 10=centred, 11=line lost.
REQ-008 The block SHALL have port obstacle, input, 1 bit: ultrasonic stop request, active high.
REQ-009 The block SHALL have port left, output, 2 bits: left wheel direction pair.
REQ-010 The block SHALL have port right, output, 2 bits: right wheel direction pair.
REQ-011 The block SHALL have port mode, output, 3 bits: PWM speed code, where 0=stop, 1=turn, 2=cruise, 3=search.
REQ-012 The block SHALL have port seq_state, output, 3 bits: current FSM state, for debug.

Function
REQ-013 The block SHALL qualify the track code: q_track updates on the edge where the raw code has been sampled FILT_CYC consecutive times; any change of the raw code restarts the count.
REQ-014 The FSM SHALL have exactly these states: IDLE=0, STRAIGHT=1, TURN_L=2, TURN_R=3, SEARCH=4, OBST_WAIT=5, HALT=6.
REQ-015 Transition priority SHALL be: enable=0, then obstacle=1, then lost-line timeout, then q_track.
REQ-016 With enable=0, the FSM SHALL enter IDLE on the next edge from any state.
REQ-017 From IDLE with enable=1, the FSM SHALL enter STRAIGHT.
REQ-018 In STRAIGHT, TURN_L and TURN_R, the next state SHALL be taken from q_track: 10->STRAIGHT, 00->TURN_L, 01->TURN_R, 11->SEARCH.
REQ-019 The block SHALL keep last_dir, updated on entry to TURN_L (L) or TURN_R (R); its reset value SHALL be L.
REQ-020 In SEARCH, the block SHALL count cycles from 0.
REQ-021 In SEARCH, q_track not equal to 11 SHALL leave SEARCH per REQ-018 and clear the count.
REQ-022 In SEARCH, the FSM SHALL enter HALT when the count reaches LOST_CYC-1.
REQ-023 HALT SHALL be sticky; it SHALL exit only through enable=0 to IDLE.
REQ-024 obstacle=1 in STRAIGHT, TURN_L, TURN_R or SEARCH SHALL enter OBST_WAIT on the next edge and clear the search count.
REQ-025 In OBST_WAIT, the block SHALL count consecutive obstacle=0 cycles; obstacle=1 SHALL reset that count to 0.
REQ-026 OBST_WAIT SHALL enter STRAIGHT when the clear count reaches HOLD_CYC-1.
REQ-027 obstacle SHALL be ignored in IDLE and HALT.
REQ-028 Outputs SHALL be a Moore decode of the state register, with {left,right,mode} as follows: STRAIGHT=1010,2; TURN_L=0010,1; TURN_R=1000,1; SEARCH = TURN_L or TURN_R pattern per last_dir, mode 3; IDLE, OBST_WAIT and HALT = 0000,0.
REQ-029 Latency from a stable raw track change to an output change SHALL be FILT_CYC+1 cycles.
REQ-030 Latency from an obstacle assertion to the 0000 output SHALL be 1 cycle.
REQ-031 All counters SHALL saturate and never wrap.

Reset
REQ-032 rst=1 SHALL asynchronously force state=IDLE, q_track=10, the filter count to 0, both counters to 0, and last_dir=L.
REQ-033 During reset, outputs SHALL read left=00, right=00, mode=0, seq_state=0.
REQ-034 Reset released mid-operation SHALL resume from IDLE, with no memory of prior HALT or obstacle.

Structure
REQ-035 Package drive_pkg SHALL hold the state encoding, the track codes, the mode codes and the left/right direction patterns.
REQ-036 Sub-module track_filter (parameter FILT_CYC) SHALL implement REQ-013.
REQ-037 The FSM and counters SHALL live in drive_sequencer.

Verification
All scenarios use FILT_CYC=4, LOST_CYC=20, HOLD_CYC=8.
REQ-038 Scenario: reset, enable=1, track=10 -> STRAIGHT after 1 edge; outputs 1010, mode 2.
REQ-039 Scenario: track 10->00 held -> 0010, mode 1 exactly 5 cycles later; a 3-cycle glitch to 01 -> no output change.
REQ-040 Scenario: after TURN_R, track=11 held -> SEARCH with 1000, mode 3; 20 cycles later -> HALT 0000; track=10 -> stays HALT until enable=0 then 1.
REQ-041 Scenario: obstacle pulse in STRAIGHT -> 0000 next cycle; clear 5 cycles, reassert, clear 8 cycles -> STRAIGHT after the 8th clear cycle only.
REQ-042 Scenario: obstacle=1 and enable=0 on the same edge -> IDLE; obstacle and timeout on the same edge -> OBST_WAIT.
REQ-043 Scenario: rst asserted mid-SEARCH between clock edges -> outputs 0000 immediately (asynchronous); after release with enable=1 -> STRAIGHT, last_dir=L.
